// File: rtl/cvxif_offload_ctrl_if.sv
// Bundle of the core-side request/completion handshake and the CV-X-IF
// issue/register/result channels driven by cvxif_offload_ctrl.
// The master modport is the offload sequencer; the slave modport is the
// side that plays the core and the coprocessor.
interface cvxif_offload_ctrl_if;
    // core request
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_instr;
    logic [31:0] req_rs0;
    logic [31:0] req_rs1;
    // core completion
    logic        cpl_valid;
    logic        cpl_ready;
    logic [1:0]  cpl_status;
    logic [31:0] cpl_data;
    // coprocessor issue
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_req_instr;
    logic        issue_resp_accept;
    logic        issue_resp_writeback;
    logic [1:0]  issue_resp_register_read;
    // coprocessor register
    logic        register_valid;
    logic        register_ready;
    logic [31:0] register_rs0;
    logic [31:0] register_rs1;
    logic [1:0]  register_rs_valid;
    // coprocessor result
    logic        result_valid;
    logic        result_ready;
    logic [31:0] result_data;

    modport master (
        input  req_valid, req_instr, req_rs0, req_rs1,
        output req_ready,
        output cpl_valid, cpl_status, cpl_data,
        input  cpl_ready,
        output issue_valid, issue_req_instr,
        input  issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
        output register_valid, register_rs0, register_rs1, register_rs_valid,
        input  register_ready,
        input  result_valid, result_data,
        output result_ready
    );

    modport slave (
        output req_valid, req_instr, req_rs0, req_rs1,
        input  req_ready,
        input  cpl_valid, cpl_status, cpl_data,
        output cpl_ready,
        input  issue_valid, issue_req_instr,
        output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read,
        input  register_valid, register_rs0, register_rs1, register_rs_valid,
        output register_ready,
        output result_valid, result_data,
        input  result_ready
    );
endinterface

// File: rtl/cvxif_offload_ctrl.sv
// Core-side offload sequencer: accepts one request at a time, walks the
// CV-X-IF issue -> register -> result handshakes, and returns a single
// completion record. A per-state watchdog (TIMEOUT cycles, 0 = off) turns a
// stalled coprocessor into a timeout completion instead of a hung core.
module cvxif_offload_ctrl #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    cvxif_offload_ctrl_if.master bus
);

    localparam bit          TIMEOUT_EN   = (TIMEOUT != 0);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK_WB   = 2'b00;
    localparam logic [1:0] ST_OK_NOWB = 2'b01;
    localparam logic [1:0] ST_REJECT  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        REG,
        WAIT_RES,
        CPL
    } state_t;

    state_t      state_reg;
    logic [15:0] count_reg;
    logic [31:0] instr_reg;
    logic [31:0] rs0_reg;
    logic [31:0] rs1_reg;
    logic [31:0] data_reg;
    logic [1:0]  status_reg;
    logic [1:0]  mask_reg;
    logic        wb_reg;
    logic        expired;

    // Last permitted waiting cycle of the current handshake state.
    assign expired = TIMEOUT_EN && (count_reg == TIMEOUT_LAST);

    // Handshake strobes come only from the state register so no input can
    // ever combinationally reach a valid/ready output.
    assign bus.req_ready         = (state_reg == IDLE);
    assign bus.issue_valid       = (state_reg == ISSUE);
    assign bus.register_valid    = (state_reg == REG);
    assign bus.result_ready      = (state_reg == WAIT_RES);
    assign bus.cpl_valid         = (state_reg == CPL);
    assign bus.issue_req_instr   = instr_reg;
    assign bus.register_rs0      = rs0_reg;
    assign bus.register_rs1      = rs1_reg;
    assign bus.register_rs_valid = mask_reg;
    assign bus.cpl_status        = status_reg;
    assign bus.cpl_data          = data_reg;

    // Sequencer: state, watchdog counter, latched request and completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            instr_reg  <= '0;
            rs0_reg    <= '0;
            rs1_reg    <= '0;
            data_reg   <= '0;
            status_reg <= ST_OK_WB;
            mask_reg   <= '0;
            wb_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.req_valid) begin
                        instr_reg <= bus.req_instr;
                        rs0_reg   <= bus.req_rs0;
                        rs1_reg   <= bus.req_rs1;
                        count_reg <= '0;
                        state_reg <= ISSUE;
                    end
                end

                ISSUE: begin
                    // Response fields are only meaningful in the handshake cycle.
                    if (bus.issue_ready) begin
                        count_reg <= '0;
                        if (!bus.issue_resp_accept) begin
                            status_reg <= ST_REJECT;
                            data_reg   <= '0;
                            state_reg  <= CPL;
                        end else begin
                            wb_reg   <= bus.issue_resp_writeback;
                            mask_reg <= bus.issue_resp_register_read;
                            if (bus.issue_resp_register_read != 2'b00) begin
                                state_reg <= REG;
                            end else if (bus.issue_resp_writeback) begin
                                state_reg <= WAIT_RES;
                            end else begin
                                status_reg <= ST_OK_NOWB;
                                data_reg   <= '0;
                                state_reg  <= CPL;
                            end
                        end
                    end else if (expired) begin
                        count_reg  <= '0;
                        status_reg <= ST_TIMEOUT;
                        data_reg   <= '0;
                        state_reg  <= CPL;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                REG: begin
                    if (bus.register_ready) begin
                        count_reg <= '0;
                        if (wb_reg) begin
                            state_reg <= WAIT_RES;
                        end else begin
                            status_reg <= ST_OK_NOWB;
                            data_reg   <= '0;
                            state_reg  <= CPL;
                        end
                    end else if (expired) begin
                        count_reg  <= '0;
                        status_reg <= ST_TIMEOUT;
                        data_reg   <= '0;
                        state_reg  <= CPL;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                WAIT_RES: begin
                    if (bus.result_valid) begin
                        count_reg  <= '0;
                        status_reg <= ST_OK_WB;
                        data_reg   <= bus.result_data;
                        state_reg  <= CPL;
                    end else if (expired) begin
                        count_reg  <= '0;
                        status_reg <= ST_TIMEOUT;
                        data_reg   <= '0;
                        state_reg  <= CPL;
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end

                CPL: begin
                    if (bus.cpl_ready) begin
                        count_reg <= '0;
                        state_reg <= IDLE;
                    end
                end

                default: begin
                    count_reg <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cvxif_offload_ctrl.sv
// Bench for cvxif_offload_ctrl. Each transaction describes the partner
// behaviour (response fields and per-channel wait times); a transaction-level
// model turns that into the expected per-cycle output schedule, and one
// compare process checks the DUT against it on every falling edge.
module tb_cvxif_offload_ctrl;

    localparam int unsigned TO = 8;

    logic clk;
    logic rst;

    cvxif_offload_ctrl_if bus();

    cvxif_offload_ctrl #(.TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs0;
        logic [31:0] rs1;
        logic        accept;
        logic        wb;
        logic [1:0]  mask;
        logic [31:0] result;
        int          d_issue;
        int          d_reg;
        int          d_res;
        int          d_cpl;
    } txn_t;

    typedef struct {
        logic        rr;
        logic        cv;
        logic        iv;
        logic        rv;
        logic        rsr;
        logic [1:0]  st;
        logic [31:0] dat;
        logic [31:0] instr;
        logic [31:0] rs0;
        logic [31:0] rs1;
        logic [1:0]  mask;
    } exp_t;

    txn_t cur;
    exp_t expq[$];
    exp_t ce;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] instr, input logic [31:0] rs0,
                                input logic [31:0] rs1, input logic accept, input logic wb,
                                input logic [1:0] mask, input logic [31:0] result,
                                input int di, input int dr, input int ds, input int dc);
        txn_t t;
        t.instr = instr; t.rs0 = rs0; t.rs1 = rs1;
        t.accept = accept; t.wb = wb; t.mask = mask; t.result = result;
        t.d_issue = di; t.d_reg = dr; t.d_res = ds; t.d_cpl = dc;
        return t;
    endfunction

    // A handshake phase whose partner waits d cycles lasts d+1 cycles,
    // unless the watchdog expires first after TO cycles.
    function automatic int phase_len(input int d, output bit to);
        if (TO != 0 && d >= int'(TO)) begin
            to = 1'b1;
            return int'(TO);
        end
        to = 1'b0;
        return d + 1;
    endfunction

    task automatic push_n(input int n, input exp_t e);
        repeat (n) expq.push_back(e);
    endtask

    // Expected schedule starting at the acceptance cycle (index 0).
    task automatic build_model(input txn_t t, output int cpl_at,
                               output logic [1:0] st, output logic [31:0] dat);
        exp_t e;
        bit   to;
        int   n;
        e.rr = 1'b1; e.cv = 1'b0; e.iv = 1'b0; e.rv = 1'b0; e.rsr = 1'b0;
        e.st = 2'b00; e.dat = '0;
        e.instr = t.instr; e.rs0 = t.rs0; e.rs1 = t.rs1; e.mask = t.mask;
        expq.push_back(e);
        e.rr   = 1'b0;
        cpl_at = 1;
        dat    = '0;
        e.iv = 1'b1; n = phase_len(t.d_issue, to); push_n(n, e); cpl_at += n; e.iv = 1'b0;
        if (to) begin
            st = 2'b11;
        end else if (!t.accept) begin
            st = 2'b10;
        end else begin
            st = 2'b01;
            if (t.mask != 2'b00) begin
                e.rv = 1'b1; n = phase_len(t.d_reg, to); push_n(n, e); cpl_at += n; e.rv = 1'b0;
            end
            if (to) begin
                st = 2'b11;
            end else if (t.wb) begin
                e.rsr = 1'b1; n = phase_len(t.d_res, to); push_n(n, e); cpl_at += n; e.rsr = 1'b0;
                if (to) st = 2'b11;
                else begin
                    st  = 2'b00;
                    dat = t.result;
                end
            end
        end
        e.cv = 1'b1; e.st = st; e.dat = dat;
        push_n(t.d_cpl + 1, e);
    endtask

    // Compare process: one expected entry per cycle while a schedule is pending.
    initial begin
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                ce = expq.pop_front();
                chk("req_ready",      32'(bus.req_ready),      32'(ce.rr));
                chk("cpl_valid",      32'(bus.cpl_valid),      32'(ce.cv));
                chk("issue_valid",    32'(bus.issue_valid),    32'(ce.iv));
                chk("register_valid", 32'(bus.register_valid), 32'(ce.rv));
                chk("result_ready",   32'(bus.result_ready),   32'(ce.rsr));
                if (ce.iv) chk("issue_req_instr", bus.issue_req_instr, ce.instr);
                if (ce.rv) begin
                    chk("register_rs0",      bus.register_rs0,           ce.rs0);
                    chk("register_rs1",      bus.register_rs1,           ce.rs1);
                    chk("register_rs_valid", 32'(bus.register_rs_valid), 32'(ce.mask));
                end
                if (ce.cv) begin
                    chk("cpl_status", 32'(bus.cpl_status), 32'(ce.st));
                    chk("cpl_data",   bus.cpl_data,        ce.dat);
                end
            end
        end
    end

    // Partner model: each ready/valid rises after the configured wait; the
    // response payloads carry wrong values outside the handshake cycle.
    int icnt, rcnt, scnt, ccnt;
    initial begin
        bus.issue_ready = 1'b0; bus.register_ready = 1'b0;
        bus.result_valid = 1'b0; bus.cpl_ready = 1'b0;
        bus.issue_resp_accept = 1'b0; bus.issue_resp_writeback = 1'b0;
        bus.issue_resp_register_read = 2'b00; bus.result_data = '0;
        icnt = 0; rcnt = 0; scnt = 0; ccnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                icnt = 0; rcnt = 0; scnt = 0; ccnt = 0;
                bus.issue_ready = 1'b0; bus.register_ready = 1'b0;
                bus.result_valid = 1'b0; bus.cpl_ready = 1'b0;
            end else begin
                if (bus.issue_valid) begin bus.issue_ready = (icnt >= cur.d_issue); icnt++; end
                else begin bus.issue_ready = 1'b0; icnt = 0; end
                if (bus.register_valid) begin bus.register_ready = (rcnt >= cur.d_reg); rcnt++; end
                else begin bus.register_ready = 1'b0; rcnt = 0; end
                if (bus.result_ready) begin bus.result_valid = (scnt >= cur.d_res); scnt++; end
                else begin bus.result_valid = 1'b0; scnt = 0; end
                if (bus.cpl_valid) begin bus.cpl_ready = (ccnt >= cur.d_cpl); ccnt++; end
                else begin bus.cpl_ready = 1'b0; ccnt = 0; end
            end
            bus.issue_resp_accept        = bus.issue_ready ? cur.accept : ~cur.accept;
            bus.issue_resp_writeback     = bus.issue_ready ? cur.wb     : ~cur.wb;
            bus.issue_resp_register_read = bus.issue_ready ? cur.mask   : ~cur.mask;
            bus.result_data              = bus.result_valid ? cur.result : $urandom;
        end
    end

    // Called exactly at a rising edge; offers the request in that cycle.
    task automatic start_txn(input txn_t t, output int cpl_at,
                             output logic [1:0] st, output logic [31:0] dat);
        #1;
        cur = t;
        build_model(t, cpl_at, st, dat);
        bus.req_valid = 1'b1;
        bus.req_instr = t.instr;
        bus.req_rs0   = t.rs0;
        bus.req_rs1   = t.rs1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_instr = $urandom;
        bus.req_rs0   = $urandom;
        bus.req_rs1   = $urandom;
    endtask

    // Returns at the rising edge that follows the last scheduled cycle.
    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (expq.size() > 0 && n < 400);
        if (expq.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain t=%0t got %0d pending want 0", name, $time, expq.size());
            expq.delete();
        end
    endtask

    task automatic run(input string name, input txn_t t, input int exp_cpl,
                       input logic [1:0] exp_st, input logic [31:0] exp_dat);
        int          at;
        logic [1:0]  st;
        logic [31:0] dat;
        start_txn(t, at, st, dat);
        chk({name, "_model_cycle"},  32'(at), 32'(exp_cpl));
        chk({name, "_model_status"}, 32'(st), 32'(exp_st));
        chk({name, "_model_data"},   dat,     exp_dat);
        wait_done(name);
        $display("txn %s cpl_cycle %0d status %0d data %h", name, at, st, dat);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"},      32'(bus.req_ready),         32'd1);
        chk({tag, "_issue_valid"},    32'(bus.issue_valid),       32'd0);
        chk({tag, "_register_valid"}, 32'(bus.register_valid),    32'd0);
        chk({tag, "_result_ready"},   32'(bus.result_ready),      32'd0);
        chk({tag, "_cpl_valid"},      32'(bus.cpl_valid),         32'd0);
        chk({tag, "_cpl_status"},     32'(bus.cpl_status),        32'd0);
        chk({tag, "_cpl_data"},       bus.cpl_data,               32'd0);
        chk({tag, "_issue_instr"},    bus.issue_req_instr,        32'd0);
        chk({tag, "_rs0"},            bus.register_rs0,           32'd0);
        chk({tag, "_rs1"},            bus.register_rs1,           32'd0);
        chk({tag, "_rs_valid"},       32'(bus.register_rs_valid), 32'd0);
    endtask

    localparam logic [31:0] I0 = 32'h0000_100B;
    localparam logic [31:0] A0 = 32'h4000_0000;
    localparam logic [31:0] B0 = 32'h3000_0000;
    localparam logic [31:0] R0 = 32'h1234_5678;

    initial begin
        int          at;
        int          n;
        logic [1:0]  st;
        logic [31:0] dat;
        cur = mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 0, 0, 0, 0);
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_instr = '0; bus.req_rs0 = '0; bus.req_rs1 = '0;
        #1;
        chk_reset("rst0");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);

        run("full",      mk(I0, A0, B0, 1'b1, 1'b1, 2'b11, R0, 0, 0, 0, 0), 4, 2'b00, R0);
        run("reject",    mk(32'h0000_200B, 32'h1, 32'h2, 1'b0, 1'b1, 2'b11, R0, 0, 0, 0, 0), 2, 2'b10, 32'd0);
        run("backpress", mk(32'hCAFE_000B, 32'hA5A5_0001, 32'h5A5A_0002, 1'b1, 1'b1, 2'b11,
                            32'hDEAD_BEEF, 3, 2, 0, 4), 9, 2'b00, 32'hDEAD_BEEF);
        run("res_tmo",   mk(32'h0000_300B, 32'h11, 32'h22, 1'b1, 1'b1, 2'b01, R0, 0, 0, 20, 0), 11, 2'b11, 32'd0);
        run("res_last",  mk(32'h0000_310B, 32'h33, 32'h44, 1'b1, 1'b1, 2'b01,
                            32'h8765_4321, 0, 0, 7, 0), 11, 2'b00, 32'h8765_4321);
        run("m00_wb0",   mk(32'h0000_400B, 32'h55, 32'h66, 1'b1, 1'b0, 2'b00, R0, 0, 0, 0, 0), 2, 2'b01, 32'd0);
        run("m00_wb1",   mk(32'h0000_410B, 32'h77, 32'h88, 1'b1, 1'b1, 2'b00,
                            32'h0BAD_F00D, 0, 0, 0, 1), 3, 2'b00, 32'h0BAD_F00D);
        run("iss_tmo",   mk(32'h0000_500B, 32'h99, 32'hAA, 1'b1, 1'b1, 2'b11, R0, 8, 0, 0, 0), 9, 2'b11, 32'd0);
        run("reg_tmo",   mk(32'h0000_510B, 32'hBB, 32'hCC, 1'b1, 1'b1, 2'b10, R0, 0, 12, 0, 0), 10, 2'b11, 32'd0);
        run("m01_wb0",   mk(32'h0000_600B, 32'hDD, 32'hEE, 1'b1, 1'b0, 2'b01, R0, 0, 1, 0, 0), 4, 2'b01, 32'd0);

        // Abort during the register phase with an asynchronous reset.
        start_txn(mk(32'h0000_700B, 32'h1111_2222, 32'h3333_4444, 1'b1, 1'b1, 2'b11, R0, 0, 6, 0, 0),
                  at, st, dat);
        n = 0;
        while (!bus.register_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_reg", 32'(bus.register_valid), 32'd1);
        #2;
        expq.delete();
        rst = 1'b1;
        #1;
        chk_reset("abort");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk_reset("abort_rel");
        @(posedge clk);
        $display("txn abort reset applied in register phase");

        run("after_rst", mk(I0, A0, B0, 1'b1, 1'b1, 2'b11, R0, 0, 0, 0, 0), 4, 2'b00, R0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cvxif_offload_ctrl.md
# cvxif_offload_ctrl

Core-side offload sequencer that drives the CV-X-IF ports of `cvxif_pau` from the CPU pipeline. It takes one offload request (instruction plus two operands) at a time and runs the issue, register and result handshakes in order. It then returns a single completion record (status plus result) to the core. A programmable timeout guarantees the core never hangs on a stalled coprocessor.

## Interface
- TIMEOUT, 1024: maximum cycles spent waiting in any one handshake state; 0 disables the timeout; legal range 0–65535.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core offers an offload request.
- req_ready  out  1  request accepted when high together with req_valid.
- req_instr  in  32  instruction word.
- req_rs0, req_rs1  in  32 each  operand values.
- cpl_valid  out  1  completion record valid; held until cpl_ready.
- cpl_ready  in  1  core consumes the completion record.
- cpl_status  out  2  00 ok with writeback, 01 ok without writeback, 10 rejected, 11 timeout.
- cpl_data  out  32  result data; 0 unless status is 00.
- issue_valid  out  1; issue_ready  in  1; issue_req_instr  out  32.
- issue_resp_accept  in  1; issue_resp_writeback  in  1; issue_resp_register_read  in  2.
- register_valid  out  1; register_ready  in  1; register_rs0, register_rs1  out  32; register_rs_valid  out  2.
- result_valid  in  1; result_ready  out  1; result_data  in  32.

## Operation
- States: IDLE, ISSUE, REG, WAIT_RES, CPL.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch instr, rs0 and rs1, clear the timeout counter, go to ISSUE.
- ISSUE:
  - issue_valid = 1; issue_req_instr = latched instr.
  - The issue response signals are sampled only in the cycle where issue_valid && issue_ready.
  - accept = 0: status 10, go to CPL.
  - accept = 1: latch writeback and the register_read mask. Next state is REG if the mask != 0, else WAIT_RES if writeback = 1, else CPL with status 01.
- REG:
  - register_valid = 1; register_rs0/rs1 = latched operands; register_rs_valid = latched mask.
  - On register_ready: go to WAIT_RES if writeback = 1, else CPL with status 01.
- WAIT_RES:
  - result_ready = 1.
  - On result_valid: latch result_data into cpl_data, status 00, go to CPL.
- CPL:
  - cpl_valid = 1 with status and data stable.
  - On cpl_ready: go to IDLE; cpl_valid drops next cycle.
- Timeout:
  - A 16-bit counter clears on every state entry and increments each cycle in ISSUE, REG and WAIT_RES while the handshake is incomplete.
  - When counter == TIMEOUT−1 and the handshake is still incomplete that cycle: go to CPL with status 11 and data 0, deasserting all coprocessor valid/ready outputs.
  - A handshake completing in that same cycle wins over the timeout.
- Only one operation is in flight at a time; req_ready is 0 in every state except IDLE.
- Outputs issue_valid, register_valid, result_ready, req_ready and cpl_valid are decoded from the registered state only, never from inputs.

## Timing
- Reset values: state IDLE; req_ready 1; issue_valid, register_valid, result_ready and cpl_valid 0; cpl_status 00; cpl_data, issue_req_instr, register_rs0/rs1 0; register_rs_valid 00; counter 0.
- Reset asserted mid-operation aborts immediately: no completion is produced, and the coprocessor valids drop asynchronously.
- Best-case latency, with all partners ready and the mask != 0:
  - request accepted at cycle 0, issue at cycle 1, register at cycle 2, result at cycle 3;
  - cpl_valid high at cycle 4.
- Each skipped phase removes one cycle.
- Valid signals stay high, with stable payload, until the matching ready is sampled; they are never withdrawn except on timeout or reset.
- Back-to-back: a new request can be accepted the cycle after the cpl handshake, giving one op per 5 cycles at best.

## Test plan
- Full path: instr 0x0000_100B, rs0 = 0x4000_0000, rs1 = 0x3000_0000; PAU answers accept = 1, writeback = 1, mask 11, result 0x1234_5678 → register_rs_valid = 11; cpl_status 00 and cpl_data 0x1234_5678 at cycle 4.
- Reject: issue_resp_accept = 0 → register_valid and result_ready never assert; cpl_status 10, cpl_data 0.
- Backpressure: issue_ready low for 3 cycles, register_ready low for 2, cpl_ready low for 4 → payloads stay stable throughout; completion data unchanged; req_ready stays 0 until the cpl handshake.
- Timeout: TIMEOUT = 8, result_valid never asserted → cpl_status 11 exactly 8 cycles after entering WAIT_RES; result_ready drops. Repeat with result_valid arriving on the 8th cycle → status 00.
- Mask 00 with writeback = 0 → REG and WAIT_RES skipped; cpl_status 01 at cycle 2.
- Reset asserted during REG → all outputs at reset values in the same cycle; a following request completes normally.
